// File: rtl/program_loader.sv
// Boot loader: framed byte stream (SYNC, N, N*BPW payload bytes, XOR CHK) -> program memory writes.
// Latency: write strobe the cycle after a word's last byte is accepted; cpu_rst drops on the edge accepting a good CHK.
// Backpressure: byte_ready is low only during the single WRITE cycle; the pending upstream byte is held there.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   byte_valid/_data/_ready  upstream byte stream with valid/ready handshake
//   program_write/_addr/_cmd one-cycle program-memory write strobe, address and command word
//   cpu_rst                  holds the core in reset until a frame verifies
//   load_done, load_error    outcome of the most recent frame
module program_loader #(
    parameter int         ADDR = 8,
    parameter int         CODE = 4,
    parameter int         WORD = ADDR + CODE,
    parameter logic [7:0] SYNC = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic            byte_ready,
    output logic            program_write,
    output logic [ADDR-1:0] program_addr,
    output logic [WORD-1:0] program_cmd,
    output logic            cpu_rst,
    output logic            load_done,
    output logic            load_error
);

    localparam int BPW  = (WORD + 7) / 8;
    localparam int SHW  = BPW * 8;
    localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;
    // Largest word count that fits in memory; an 8-bit N can never exceed 256.
    localparam int MAX_WORDS = (ADDR < 8) ? (1 << ADDR) : 256;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [ADDR-1:0] addr_d;
    logic [SHW-1:0]  shift_q, shift_d;
    logic [7:0]      words_q, words_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [7:0]      acc_q, acc_d;
    logic            cpu_rst_d, done_d, err_d;
    logic            accept;

    assign byte_ready    = (state_q != WRITE);
    assign program_write = (state_q == WRITE);
    assign accept        = byte_valid && byte_ready;
    // Big-endian assembly: the last byte shifted in lands in the low bits.
    assign program_cmd   = shift_q[WORD-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            program_addr <= '0;
            shift_q      <= '0;
            words_q      <= '0;
            idx_q        <= '0;
            acc_q        <= '0;
            cpu_rst      <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            state_q      <= state_d;
            program_addr <= addr_d;
            shift_q      <= shift_d;
            words_q      <= words_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            cpu_rst      <= cpu_rst_d;
            load_done    <= done_d;
            load_error   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = program_addr;
        shift_d   = shift_q;
        words_d   = words_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        cpu_rst_d = cpu_rst;
        done_d    = load_done;
        err_d     = load_error;

        case (state_q)
            IDLE, DONE, ERROR: begin
                // Only SYNC opens a frame; anything else is consumed and dropped.
                if (accept && byte_data == SYNC) begin
                    state_d   = COUNT;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    acc_d     = '0;
                    cpu_rst_d = 1'b1;
                end
            end
            COUNT: begin
                if (accept) begin
                    words_d = byte_data;
                    addr_d  = '0;
                    idx_d   = '0;
                    acc_d   = acc_q ^ byte_data;
                    if (byte_data == 8'd0) begin
                        state_d = CHECK;
                    end else if (int'(byte_data) > MAX_WORDS) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    shift_d = (shift_q << 8) | SHW'(byte_data);
                    acc_d   = acc_q ^ byte_data;
                    if (idx_q == IDXW'(BPW - 1)) begin
                        idx_d   = '0;
                        state_d = WRITE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                // Address wraps naturally at ADDR bits.
                addr_d  = program_addr + 1'b1;
                words_d = words_q - 8'd1;
                state_d = (words_q == 8'd1) ? CHECK : DATA;
            end
            CHECK: begin
                if (accept) begin
                    if (byte_data == acc_q) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam int ADDR = 8;
    localparam int WORD = 12;
    localparam int BPW  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            byte_valid;
    logic [7:0]      byte_data;
    logic            byte_ready;
    logic            program_write;
    logic [ADDR-1:0] program_addr;
    logic [WORD-1:0] program_cmd;
    logic            cpu_rst;
    logic            load_done;
    logic            load_error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_wr = -100;
    logic [ADDR+WORD-1:0] got_q[$];

    program_loader dut (
        .clk          (clk),
        .rst          (rst),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .program_write(program_write),
        .program_addr (program_addr),
        .program_cmd  (program_cmd),
        .cpu_rst      (cpu_rst),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Continuous observation: ready is low exactly in write cycles, the core is held
    // in reset while writing, and writes are never closer than BPW+1 cycles.
    always @(negedge clk) begin
        if (!rst) begin
            check("ready_vs_write", 32'(byte_ready), 32'(!program_write));
            if (program_write) begin
                got_q.push_back({program_addr, program_cmd});
                check("cpu_rst_in_write", 32'(cpu_rst), 32'd1);
                check("write_gap", 32'((cyc - last_wr) >= BPW + 1), 32'd1);
                last_wr = cyc;
            end
        end
    end

    // Reference model: parse the frame from its definition.
    task automatic model(input logic [7:0] f[$], output logic [ADDR+WORD-1:0] exp_w[$],
                         output bit ok, output int n);
        logic [7:0]  x;
        logic [31:0] w;
        exp_w.delete();
        n = int'(f[1]);
        x = 8'h00;
        for (int i = 1; i < f.size() - 1; i++) x = x ^ f[i];
        ok = (f[f.size()-1] == x);
        for (int k = 0; k < n; k++) begin
            w = 0;
            for (int j = 0; j < BPW; j++) w = (w << 8) | 32'(f[2 + k*BPW + j]);
            exp_w.push_back({ADDR'(k % (1 << ADDR)), w[WORD-1:0]});
        end
    endtask

    task automatic build_frame(input int n, input bit rand_words, input bit corrupt,
                               output logic [7:0] f[$]);
        logic [7:0]  x;
        logic [15:0] w;
        f.delete();
        f.push_back(8'hA5);
        f.push_back(8'(n));
        x = 8'(n);
        for (int k = 0; k < n; k++) begin
            w = rand_words ? 16'($urandom) : 16'(k);
            f.push_back(w[15:8]);
            f.push_back(w[7:0]);
            x = x ^ w[15:8] ^ w[7:0];
        end
        if (corrupt) x = x ^ (8'h01 << $urandom_range(0, 7));
        f.push_back(x);
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle before each byte, 2 random idle cycles.
    task automatic send_byte(input logic [7:0] b, input int gap_mode);
        int gaps;
        bit taken;
        gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        byte_valid = 1'b0;
        repeat (gaps) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        taken      = 1'b0;
        for (int t = 0; t < 16 && !taken; t++) begin
            taken = byte_ready;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        check("byte_accepted", 32'(taken), 32'd1);
    endtask

    task automatic run_frame(input logic [7:0] f[$], input int gap_mode);
        logic [ADDR+WORD-1:0] exp_w[$];
        bit ok;
        int n;
        model(f, exp_w, ok, n);
        got_q.delete();
        foreach (f[i]) send_byte(f[i], gap_mode);
        repeat (3) @(negedge clk);
        check("write_count", 32'(got_q.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got_q.size(); i++)
            check("write_addr_cmd", 32'(got_q[i]), 32'(exp_w[i]));
        check("load_done", 32'(load_done), 32'(ok));
        check("load_error", 32'(load_error), 32'(!ok));
        check("cpu_rst", 32'(cpu_rst), 32'(!ok));
        check("final_addr", 32'(program_addr), 32'(n % (1 << ADDR)));
    endtask

    task automatic apply_reset();
        byte_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got_q.delete();
    endtask

    task automatic check_reset_vals();
        check("rst_byte_ready", 32'(byte_ready), 32'd1);
        check("rst_program_write", 32'(program_write), 32'd0);
        check("rst_program_addr", 32'(program_addr), 32'd0);
        check("rst_program_cmd", 32'(program_cmd), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);
    endtask

    initial begin
        logic [7:0] f1[$];
        logic [7:0] f[$];
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        @(negedge clk);
        apply_reset();
        check_reset_vals();

        // Good frame: 0x123@0, 0x456@1.
        f1 = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h04, 8'h56, 8'h72};
        run_frame(f1, 0);

        // Same frame, bad checksum.
        f = f1;
        f[6] = 8'h00;
        run_frame(f, 0);

        // Empty frame, then a new SYNC re-arms the reset.
        f = '{8'hA5, 8'h00, 8'h00};
        run_frame(f, 0);
        send_byte(8'hA5, 0);
        check("sync_sets_cpu_rst", 32'(cpu_rst), 32'd1);
        check("sync_clears_done", 32'(load_done), 32'd0);

        // Junk in idle, then the good frame with byte_valid toggling.
        apply_reset();
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        run_frame(f1, 1);

        // Reset mid-frame after three payload bytes.
        apply_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h23, 0);
        send_byte(8'h04, 0);
        apply_reset();
        repeat (4) @(negedge clk);
        check("abort_no_stray_write", 32'(got_q.size()), 32'd0);
        check_reset_vals();
        run_frame(f1, 0);

        // Randomized frames, some with corrupted checksum.
        for (int r = 0; r < 10; r++) begin
            build_frame($urandom_range(0, 6), 1'b1, ($urandom_range(0, 2) == 0), f);
            run_frame(f, 2);
        end

        // Full 255-word frame: last write 0x0FE@0xFE, address ends at 0xFF.
        build_frame(255, 1'b0, 1'b0, f);
        run_frame(f, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
